// File: rtl/tqvp_rejunity_vga_dbuf_if.sv
// TinyQV peripheral register bus between the CPU slot and the VGA line renderer.
interface tqvp_rejunity_vga_dbuf_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (output address, data_in, data_write_n, data_read_n,
                  input  data_out, data_ready);
  modport slave  (input  address, data_in, data_write_n, data_read_n,
                  output data_out, data_ready);
endinterface

// File: rtl/tqvp_rejunity_vga_dbuf.sv
// Multi-bpp VGA line renderer with palette, double-buffered line VRAM swapped on
// vblank, own timing generator, register file and vblank interrupt.
module tqvp_rejunity_vga_dbuf #(
  parameter int BPP         = 2,
  parameter int LINE_PIXELS = 128,
  parameter int H_ACTIVE    = 1024,
  parameter int H_FP        = 24,
  parameter int H_SYNC      = 136,
  parameter int H_BP        = 160,
  parameter int V_ACTIVE    = 768,
  parameter int V_FP        = 3,
  parameter int V_SYNC      = 6,
  parameter int V_BP        = 29,
  parameter bit SYNC_NEG    = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [7:0]                     ui_in,
  tqvp_rejunity_vga_dbuf_if.slave        bus,
  output logic [7:0]                     uo_out,
  output logic                           user_interrupt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);
  localparam int SCALE   = H_ACTIVE / LINE_PIXELS;
  localparam int SH      = $clog2(SCALE);
  localparam int IW      = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
  localparam int NWORDS  = (LINE_PIXELS * BPP + 31) / 32;
  localparam int NB      = NWORDS * 32;
  localparam int BW      = $clog2(NB);
  localparam int WW      = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_HS0  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] X_HS1  = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACT  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_VS0  = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] Y_VS1  = YW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [7:0]    UO_IDLE = {SYNC_NEG, 3'b000, SYNC_NEG, 3'b000};

  logic [XW-1:0]                   x_q, x_d;
  logic [YW-1:0]                   y_q, y_d;
  logic                            disp_q, disp_d, pending_q, pending_d, irq_q, irq_d;
  logic [3:0][5:0]                 pal_q, pal_d;
  logic [1:0][NWORDS-1:0][31:0]    vram_q, vram_d;
  logic [7:0]                      uo_q, uo_d;

  logic            wr_en, rd_en, vram_sel, pal_sel, ctrl_sel, status_sel;
  logic [WW-1:0]   waddr;
  logic            hblank, vblank, active, vbs, hs_act, vs_act;
  logic [NB-1:0]   bank_disp;
  logic [IW-1:0]   idx;
  logic [BW-1:0]   bitpos;
  logic [BPP-1:0]  pix;
  logic [5:0]      colour;
  logic [31:0]     rdata;

  logic unused_ui;
  assign unused_ui = ^ui_in;

  always_comb begin
    wr_en      = bus.data_write_n != 2'b11;
    rd_en      = bus.data_read_n  != 2'b11;
    waddr      = WW'(bus.address[4:2]);
    vram_sel   = !bus.address[5] && (int'(bus.address[4:2]) < NWORDS);
    pal_sel    = bus.address[5:2] == 4'b1100;
    ctrl_sel   = bus.address == 6'h38;
    status_sel = bus.address == 6'h3C;

    hblank = x_q >= X_ACT;
    vblank = y_q >= Y_ACT;
    active = !hblank && !vblank;
    vbs    = (x_q == '0) && (y_q == Y_ACT);
    hs_act = (x_q >= X_HS0) && (x_q < X_HS1);
    vs_act = (y_q >= Y_VS0) && (y_q < Y_VS1);

    x_d = (x_q == X_LAST) ? '0 : x_q + XW'(1);
    y_d = y_q;
    if (x_q == X_LAST) y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);

    // Pending is resolved after the CPU write so a set landing on the vblank
    // cycle still swaps and leaves nothing pending.
    disp_d    = disp_q;
    pending_d = pending_q;
    irq_d     = irq_q;
    if (wr_en && ctrl_sel && bus.data_in[1]) pending_d = 1'b1;
    if (wr_en && ctrl_sel && bus.data_in[0] && !bus.data_in[1]) disp_d = ~disp_d;
    if (vbs) begin
      irq_d = 1'b1;
      if (pending_d) begin
        disp_d    = ~disp_d;
        pending_d = 1'b0;
      end
    end else if (wr_en && status_sel) begin
      irq_d = 1'b0;
    end

    pal_d = pal_q;
    if (wr_en && pal_sel) pal_d[bus.address[1:0]] = bus.data_in[5:0];

    // Only full-word writes reach VRAM, and only the hidden bank.
    vram_d = vram_q;
    if (bus.data_write_n == 2'b10 && vram_sel) vram_d[~disp_q][waddr] = bus.data_in;

    bank_disp = vram_q[disp_q];
    idx       = x_q[SH +: IW];
    bitpos    = BW'(idx) * BW'(BPP);
    pix       = bank_disp[bitpos +: BPP];
    colour    = active ? pal_q[2'(pix)] : 6'd0;
    uo_d      = {hs_act ^ SYNC_NEG, colour[5], colour[3], colour[1],
                 vs_act ^ SYNC_NEG, colour[4], colour[2], colour[0]};

    rdata = '0;
    if (vram_sel)        rdata = vram_q[~disp_q][waddr];
    else if (pal_sel)    rdata = {26'd0, pal_q[bus.address[1:0]]};
    else if (ctrl_sel)   rdata = {30'd0, pending_q, disp_q};
    else if (status_sel) rdata = {irq_q, 13'd0, hblank, vblank, 6'd0, 10'(y_q)};
  end

  assign bus.data_out   = rd_en ? rdata : 32'd0;
  assign bus.data_ready = 1'b1;
  assign uo_out         = uo_q;
  assign user_interrupt = irq_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q       <= '0;
      y_q       <= '0;
      disp_q    <= 1'b0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
      pal_q     <= {6'b111111, 6'b101010, 6'b010101, 6'b000000};
      uo_q      <= UO_IDLE;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
      pal_q     <= pal_d;
      uo_q      <= uo_d;
    end
  end

  always_ff @(posedge clk) vram_q <= vram_d;
endmodule

// File: tb/tb_tqvp_rejunity_vga_dbuf.sv
// Scoreboard bench: stimulus queues expectations tagged with the cycle they are due,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_tqvp_rejunity_vga_dbuf;
  localparam int HT = 1344;
  localparam int VT = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui_in = 8'd0;
  logic [7:0] uo_out;
  logic       user_interrupt;

  tqvp_rejunity_vga_dbuf_if bus();

  tqvp_rejunity_vga_dbuf #(
    .BPP(2), .LINE_PIXELS(128),
    .H_ACTIVE(1024), .H_FP(24), .H_SYNC(136), .H_BP(160),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_NEG(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .bus(bus),
    .uo_out(uo_out), .user_interrupt(user_interrupt)
  );

  always #5 clk = ~clk;

  // Reference beam position, matching the DUT counters after each edge.
  int cyc = 0, mx = 0, my = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      mx <= 0; my <= 0;
    end else if (mx == HT - 1) begin
      mx <= 0; my <= (my == VT - 1) ? 0 : my + 1;
    end else begin
      mx <= mx + 1;
    end
  end

  typedef struct {
    int          cyc;
    int          sel;   // 0 data_out, 1 uo_out, 2 user_interrupt, 3 beam x (wait bound)
    logic [31:0] mask;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   checks = 0, fails = 0;
  bit   done = 1'b0;

  task automatic expect_at(int c, int sel, logic [31:0] mask, logic [31:0] exp, string name);
    chk_t e;
    int   i;
    e.cyc = c; e.sel = sel; e.mask = mask; e.exp = exp; e.name = name;
    i = q.size();
    while (i > 0 && q[i-1].cyc > c) i--;
    q.insert(i, e);
  endtask

  always @(negedge clk) begin : mon
    logic [31:0] act;
    chk_t        e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      case (e.sel)
        0:       act = bus.data_out;
        1:       act = {24'd0, uo_out};
        2:       act = {31'd0, user_interrupt};
        default: act = mx;
      endcase
      checks++;
      if (e.cyc != cyc || (act & e.mask) != e.exp) begin
        fails++;
        $display("FAIL %s: got %h want %h (cycle %0d due %0d)",
                 e.name, act & e.mask, e.exp, cyc, e.cyc);
      end
    end
    if (done) begin
      while (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        fails++;
        $display("FAIL %s: never sampled, want %h", e.name, e.exp);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [5:0] a, logic [31:0] d, logic [1:0] wn);
    bus.address = a; bus.data_in = d; bus.data_write_n = wn;
    tick();
    bus.data_write_n = 2'b11;
  endtask

  task automatic rd(logic [5:0] a, logic [31:0] exp, string name);
    bus.address = a; bus.data_read_n = 2'b10;
    expect_at(cyc, 0, 32'hFFFF_FFFF, exp, name);
    tick();
    bus.data_read_n = 2'b11;
  endtask

  task automatic wait_xy(int x, int y, string name);
    int n = 0;
    while (!(mx == x && my == y) && n < 20000) begin
      tick();
      n++;
    end
    if (n >= 20000) expect_at(cyc, 3, 32'hFFFF_FFFF, x, {"timeout_", name});
  endtask

  initial begin
    logic [7:0] px_uo [4];
    px_uo[0] = 8'h88; px_uo[1] = 8'h8F; px_uo[2] = 8'hF8; px_uo[3] = 8'hFF;
    bus.address = '0; bus.data_in = '0;
    bus.data_write_n = 2'b11; bus.data_read_n = 2'b11;

    repeat (3) tick();
    expect_at(cyc, 1, 32'hFF, 32'h88, "rst_uo");
    expect_at(cyc, 2, 32'h1, 32'h0, "rst_irq");
    rst_n = 1'b1;
    rd(6'h38, 32'h0, "rst_ctrl");
    rd(6'h3C, 32'h0, "rst_status");
    rd(6'h33, 32'h3F, "rst_pal3");
    rd(6'h31, 32'h15, "rst_pal1");

    // Fill write bank 1: pixels 0..3 = 0,1,2,3 repeating, pixel 127 = 0.
    wr(6'h00, 32'hE4E4_E4E4, 2'b10);
    wr(6'h04, 32'h1234_5678, 2'b10);
    for (int w = 2; w < 8; w++) wr(6'(w * 4), 32'h0, 2'b10);
    rd(6'h00, 32'hE4E4_E4E4, "vram_w0");
    wr(6'h04, 32'hFFFF_FFFF, 2'b00);
    wr(6'h04, 32'hFFFF_FFFF, 2'b01);
    rd(6'h04, 32'h1234_5678, "vram_narrow_ignored");
    wr(6'h38, 32'h2, 2'b10);
    rd(6'h38, 32'h2, "ctrl_pending");

    // hsync low for x in [1048,1184), seen one cycle later on uo_out.
    wait_xy(1048, 0, "hs");
    expect_at(cyc,       1, 32'h80, 32'h80, "hs_before");
    expect_at(cyc + 1,   1, 32'h80, 32'h00, "hs_first");
    expect_at(cyc + 136, 1, 32'h80, 32'h00, "hs_last");
    expect_at(cyc + 137, 1, 32'h80, 32'h80, "hs_after");

    wait_xy(0, 4, "vbs1");
    tick();
    expect_at(cyc, 2, 32'h1, 32'h1, "irq_set");
    rd(6'h38, 32'h1, "ctrl_swapped");
    rd(6'h3C, 32'h8001_0004, "status_vblank");

    wait_xy(0, 0, "frame2");
    for (int k = 0; k < 32; k++)
      expect_at(cyc + k + 1, 1, 32'hFF, {24'd0, px_uo[k / 8]}, "pixel");

    wait_xy(40, 0, "pal");
    wr(6'h30, 32'h30, 2'b00);
    rd(6'h30, 32'h30, "pal0_rd");
    wait_xy(1024, 1, "blank");
    expect_at(cyc,      1, 32'hFF, 32'hCC, "active_pal0");
    expect_at(cyc + 1,  1, 32'hFF, 32'h88, "blank_pal0");
    expect_at(cyc + 77, 1, 32'h7F, 32'h08, "blank_in_hsync");
    repeat (80) tick();

    wr(6'h3C, 32'h0, 2'b10);
    expect_at(cyc, 2, 32'h1, 32'h0, "irq_clear");
    wait_xy(0, 4, "vbs2");
    wr(6'h3C, 32'h0, 2'b10);
    expect_at(cyc, 2, 32'h1, 32'h1, "irq_set_wins");
    expect_at(cyc, 1, 32'hFF, 32'h88, "vblank_colour");
    rd(6'h38, 32'h1, "ctrl_no_swap");
    wr(6'h3C, 32'h0, 2'b00);
    expect_at(cyc, 2, 32'h1, 32'h0, "irq_clear2");
    wait_xy(1, 5, "vs");
    expect_at(cyc, 1, 32'hFF, 32'h80, "vsync_low");

    wr(6'h38, 32'h1, 2'b10);
    rd(6'h38, 32'h0, "force_swap0");
    wr(6'h38, 32'h1, 2'b00);
    rd(6'h38, 32'h1, "force_swap1");

    wait_xy(500, 1, "midrst");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expect_at(cyc, 1, 32'hFF, 32'h88, "midrst_uo");
    rd(6'h3C, 32'h0, "midrst_status");
    rd(6'h38, 32'h0, "midrst_ctrl");

    repeat (3) tick();
    done = 1'b1;
  end
endmodule
